// File: rtl/pu_msp430_sfr_irq.sv
// ----------------------------------------------------------------------------
// pu_msp430_sfr_irq
//
// Interrupt special-function-register block. Captures up to 16 asynchronous
// interrupt sources with per-channel edge selection, holds them in software
// visible enable/flag registers and presents a prioritised vector to the CPU.
//
// Register map (byte offsets from BASE_ADDR):
//   0x0 IE      enable mask                     RW
//   0x2 IES     edge select, 1 = falling edge   RW
//   0x4 IFG     interrupt flags                 RW
//   0x6 IFGSET  write-1-to-set flags            W, reads 0
//   0x8 IFGCLR  write-1-to-clear flags          W, reads 0
//   0xA IV      {irq_vec, 1'b0}; reading it clears the reported flag
//
// Ports:
//   mclk, puc_rst   clock, asynchronous active-high reset
//   irq_src         interrupt sources (asynchronous, glitch-free)
//   irq_acc         CPU accepted the pending interrupt (1-cycle pulse)
//   per_addr/din/en/we  peripheral bus (word address, byte write enables)
//   per_dout        read data, 0 when not selected
//   irq_pnd         any enabled flag set
//   irq_vec         index+1 of lowest-numbered pending channel, 0 if none
//   irq_wkup        wakeup request, same as irq_pnd
// ----------------------------------------------------------------------------
module pu_msp430_sfr_irq #(
    parameter logic [14:0] BASE_ADDR   = 15'h0100,
    parameter int          DEC_WD      = 4,
    parameter int          NUM_CH      = 8,
    parameter int          SYNC_STAGES = 2
) (
    input  logic              mclk,
    input  logic              puc_rst,
    input  logic [NUM_CH-1:0] irq_src,
    input  logic              irq_acc,
    input  logic [13:0]       per_addr,
    input  logic [15:0]       per_din,
    input  logic              per_en,
    input  logic [1:0]        per_we,
    output logic [15:0]       per_dout,
    output logic              irq_pnd,
    output logic [4:0]        irq_vec,
    output logic              irq_wkup
);
    localparam int OW = DEC_WD - 1;
    localparam logic [OW-1:0] OFS_IE  = OW'(0);
    localparam logic [OW-1:0] OFS_IES = OW'(1);
    localparam logic [OW-1:0] OFS_IFG = OW'(2);
    localparam logic [OW-1:0] OFS_SET = OW'(3);
    localparam logic [OW-1:0] OFS_CLR = OW'(4);
    localparam logic [OW-1:0] OFS_IV  = OW'(5);

    // Bits at or above NUM_CH never hold state and always read 0.
    localparam logic [15:0] CH_MASK = 16'((32'd1 << NUM_CH) - 32'd1);

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic          reg_sel;
    logic [OW-1:0] word_ofs;
    logic          rd_en;
    logic          wr_en;
    logic [15:0]   wmask;
    logic          iv_rd;

    assign reg_sel  = per_en && (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
    assign word_ofs = per_addr[OW-1:0];
    assign rd_en    = reg_sel && (per_we == 2'b00);
    assign wr_en    = reg_sel && (per_we != 2'b00);
    assign wmask    = {{8{per_we[1]}}, {8{per_we[0]}}} & CH_MASK;
    assign iv_rd    = rd_en && (word_ofs == OFS_IV);

    // Per-bit write strobes for each register, already byte- and channel-masked
    logic [15:0] ie_wr_bits;
    logic [15:0] ies_wr_bits;
    logic [15:0] ifg_wr_bits;
    logic [15:0] set_bits;
    logic [15:0] clr_bits;

    assign ie_wr_bits  = (wr_en && (word_ofs == OFS_IE))  ? wmask : 16'h0000;
    assign ies_wr_bits = (wr_en && (word_ofs == OFS_IES)) ? wmask : 16'h0000;
    assign ifg_wr_bits = (wr_en && (word_ofs == OFS_IFG)) ? wmask : 16'h0000;
    assign set_bits    = (wr_en && (word_ofs == OFS_SET)) ? (wmask & per_din) : 16'h0000;
    assign clr_bits    = (wr_en && (word_ofs == OFS_CLR)) ? (wmask & per_din) : 16'h0000;

    // ------------------------------------------------------------------
    // IE / IES registers
    // ------------------------------------------------------------------
    logic [15:0] ie_reg;
    logic [15:0] ies_reg;

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            ie_reg  <= 16'h0000;
            ies_reg <= 16'h0000;
        end else begin
            ie_reg  <= (ie_reg  & ~ie_wr_bits)  | (per_din & ie_wr_bits);
            ies_reg <= (ies_reg & ~ies_wr_bits) | (per_din & ies_wr_bits);
        end
    end

    // ------------------------------------------------------------------
    // Prioritisation: lowest channel index wins
    // ------------------------------------------------------------------
    logic [15:0] ifg_vec;
    logic [15:0] pending;
    logic        vec_clr;

    assign pending = ifg_vec & ie_reg;

    always_comb begin
        irq_vec = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            if (pending[i]) irq_vec = 5'(i + 1);
        end
    end

    assign irq_pnd  = |pending;
    assign irq_wkup = irq_pnd;

    // IV read and irq_acc in the same cycle still clear only one channel.
    assign vec_clr = (iv_rd || irq_acc) && (irq_vec != 5'd0);

    // ------------------------------------------------------------------
    // Per-channel edge detection and flag
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_ch
            if (gi < NUM_CH) begin : g_live
                logic s;
                logic pol;
                logic dly_reg;
                logic ifg_reg;
                logic edge_det;

                if (SYNC_STAGES == 0) begin : g_nosync
                    assign s = irq_src[gi];
                end else begin : g_sync
                    logic [SYNC_STAGES-1:0] sync_reg;
                    always_ff @(posedge mclk or posedge puc_rst) begin
                        if (puc_rst) sync_reg <= '0;
                        else         sync_reg <= SYNC_STAGES'({sync_reg, irq_src[gi]});
                    end
                    assign s = sync_reg[SYNC_STAGES-1];
                end

                assign pol      = s ^ ies_reg[gi];
                assign edge_det = pol & ~dly_reg;

                // On an IES write the delay flop takes the post-write polarity
                // so flipping the edge select never looks like a source edge.
                always_ff @(posedge mclk or posedge puc_rst) begin
                    if (puc_rst)              dly_reg <= 1'b0;
                    else if (ies_wr_bits[gi]) dly_reg <= s ^ per_din[gi];
                    else                      dly_reg <= pol;
                end

                // A captured edge beats every kind of clear in the same cycle.
                always_ff @(posedge mclk or posedge puc_rst) begin
                    if (puc_rst)                                  ifg_reg <= 1'b0;
                    else if (edge_det)                            ifg_reg <= 1'b1;
                    else if (set_bits[gi])                        ifg_reg <= 1'b1;
                    else if (ifg_wr_bits[gi])                     ifg_reg <= per_din[gi];
                    else if (clr_bits[gi])                        ifg_reg <= 1'b0;
                    else if (vec_clr && (irq_vec == 5'(gi + 1)))  ifg_reg <= 1'b0;
                end

                assign ifg_vec[gi] = ifg_reg;
            end else begin : g_tie
                assign ifg_vec[gi] = 1'b0;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        per_dout = 16'h0000;
        if (rd_en) begin
            case (word_ofs)
                OFS_IE:  per_dout = ie_reg;
                OFS_IES: per_dout = ies_reg;
                OFS_IFG: per_dout = ifg_vec;
                OFS_IV:  per_dout = {10'b0, irq_vec, 1'b0};
                default: per_dout = 16'h0000;
            endcase
        end
    end

endmodule

// File: tb/tb_pu_msp430_sfr_irq.sv
// ----------------------------------------------------------------------------
// tb_pu_msp430_sfr_irq
//
// Self-checking bench for pu_msp430_sfr_irq with default parameters
// (BASE_ADDR 0x0100, NUM_CH 8, SYNC_STAGES 2). Expected values are queued
// when a transaction is driven and popped when the DUT output is sampled.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// ----------------------------------------------------------------------------
module tb_pu_msp430_sfr_irq;

    logic        mclk;
    logic        puc_rst;
    logic [7:0]  irq_src;
    logic        irq_acc;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;
    logic        irq_pnd;
    logic [4:0]  irq_vec;
    logic        irq_wkup;

    // Word addresses of the registers (byte base 0x0100 -> word 0x0080)
    localparam logic [13:0] A_IE    = 14'h0080;
    localparam logic [13:0] A_IES   = 14'h0081;
    localparam logic [13:0] A_IFG   = 14'h0082;
    localparam logic [13:0] A_SET   = 14'h0083;
    localparam logic [13:0] A_CLR   = 14'h0084;
    localparam logic [13:0] A_IV    = 14'h0085;
    localparam logic [13:0] A_UNUSD = 14'h0086;
    localparam logic [13:0] A_OTHER = 14'h0088;

    pu_msp430_sfr_irq #(
        .BASE_ADDR   (15'h0100),
        .DEC_WD      (4),
        .NUM_CH      (8),
        .SYNC_STAGES (2)
    ) dut (
        .mclk     (mclk),
        .puc_rst  (puc_rst),
        .irq_src  (irq_src),
        .irq_acc  (irq_acc),
        .per_addr (per_addr),
        .per_din  (per_din),
        .per_en   (per_en),
        .per_we   (per_we),
        .per_dout (per_dout),
        .irq_pnd  (irq_pnd),
        .irq_vec  (irq_vec),
        .irq_wkup (irq_wkup)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%04h, want 0x%04h", tag, obs, exp);
        end else begin
            $display("pass %s: 0x%04h", tag, obs);
        end
    endtask

    task automatic sb_push(input string tag, input logic [15:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [15:0] obs);
        sb_t e;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", obs, obs ^ 16'hFFFF);
        end else begin
            e = sb_q.pop_front();
            check_val(e.tag, obs, e.exp);
        end
    endtask

    // All tasks start and end on (or just after) a falling edge.
    task automatic bus_wr(input logic [13:0] addr, input logic [15:0] data, input logic [1:0] we);
        per_en   = 1'b1;
        per_addr = addr;
        per_din  = data;
        per_we   = we;
        @(negedge mclk);
        per_en   = 1'b0;
        per_we   = 2'b00;
        per_din  = 16'h0000;
    endtask

    task automatic bus_rd(input logic [13:0] addr, input string tag, input logic [15:0] exp,
                          input logic acc);
        per_en   = 1'b1;
        per_addr = addr;
        per_we   = 2'b00;
        irq_acc  = acc;
        sb_push(tag, exp);
        #1;
        sb_pop(per_dout);
        @(negedge mclk);
        per_en   = 1'b0;
        irq_acc  = 1'b0;
    endtask

    task automatic chk_stat(input string tag, input logic exp_pnd, input logic [4:0] exp_vec);
        sb_push({tag, ".pnd"},  16'(exp_pnd));
        sb_push({tag, ".vec"},  16'(exp_vec));
        sb_push({tag, ".wkup"}, 16'(exp_pnd));
        #1;
        sb_pop(16'(irq_pnd));
        sb_pop(16'(irq_vec));
        sb_pop(16'(irq_wkup));
    endtask

    task automatic pulse_acc();
        irq_acc = 1'b1;
        @(negedge mclk);
        irq_acc = 1'b0;
    endtask

    // Safety net: the stimulus below is a fixed-length sequence.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        irq_src  = 8'h00;
        irq_acc  = 1'b0;
        per_addr = 14'h0000;
        per_din  = 16'h0000;
        per_en   = 1'b0;
        per_we   = 2'b00;
        puc_rst  = 1'b1;
        repeat (2) @(negedge mclk);

        // Reset state
        chk_stat("rst", 1'b0, 5'd0);
        sb_push("rst.dout", 16'h0000);
        sb_pop(per_dout);
        @(negedge mclk);
        puc_rst = 1'b0;
        bus_rd(A_IE,  "rst.ie",  16'h0000, 1'b0);
        bus_rd(A_IES, "rst.ies", 16'h0000, 1'b0);
        bus_rd(A_IFG, "rst.ifg", 16'h0000, 1'b0);

        // Rising edge on ch3, sync latency, IV read clears it
        bus_wr(A_IE, 16'h00FF, 2'b11);
        bus_rd(A_IE, "ie.ff", 16'h00FF, 1'b0);
        irq_src[3] = 1'b1;
        repeat (2) @(negedge mclk);
        chk_stat("src3.early", 1'b0, 5'd0);
        @(negedge mclk);
        chk_stat("src3", 1'b1, 5'd4);
        bus_rd(A_IFG, "src3.ifg",    16'h0008, 1'b0);
        bus_rd(A_IV,  "src3.iv",     16'h0008, 1'b0);
        bus_rd(A_IFG, "src3.iv_clr", 16'h0000, 1'b0);
        irq_src[3] = 1'b0;
        chk_stat("src3.clr", 1'b0, 5'd0);

        // IFGSET, priority, irq_acc clears highest priority in turn
        bus_wr(A_IE,  16'h0022, 2'b11);
        bus_wr(A_SET, 16'h0022, 2'b11);
        bus_rd(A_IFG, "set22.ifg", 16'h0022, 1'b0);
        chk_stat("set22", 1'b1, 5'd2);
        pulse_acc();
        bus_rd(A_IFG, "acc1.ifg", 16'h0020, 1'b0);
        chk_stat("acc1", 1'b1, 5'd6);
        pulse_acc();
        bus_rd(A_IFG, "acc2.ifg", 16'h0000, 1'b0);
        chk_stat("acc2", 1'b0, 5'd0);

        // Edge-select change never creates an edge; falling edge then detected
        irq_src[2] = 1'b1;
        repeat (4) @(negedge mclk);
        bus_wr(A_CLR, 16'h0004, 2'b11);
        bus_rd(A_IFG, "ch2.pre", 16'h0000, 1'b0);
        bus_wr(A_IES, 16'h0006, 2'b11);
        repeat (4) @(negedge mclk);
        bus_rd(A_IFG, "ies.no_edge", 16'h0000, 1'b0);
        bus_rd(A_IES, "ies.rd",      16'h0006, 1'b0);
        irq_src[2] = 1'b0;
        repeat (3) @(negedge mclk);
        bus_rd(A_IFG, "ies.fall", 16'h0004, 1'b0);
        bus_wr(A_IES, 16'h0000, 2'b11);
        bus_wr(A_CLR, 16'h0004, 2'b11);
        repeat (3) @(negedge mclk);
        bus_rd(A_IFG, "ies.restore", 16'h0000, 1'b0);

        // Edge on ch0 in the same cycle as IFGCLR of ch0: edge wins
        irq_src[0] = 1'b1;
        repeat (2) @(negedge mclk);
        bus_wr(A_CLR, 16'h0001, 2'b11);
        bus_rd(A_IFG, "edge_vs_clr", 16'h0001, 1'b0);
        bus_wr(A_CLR, 16'h0001, 2'b11);
        bus_rd(A_IFG, "clr0", 16'h0000, 1'b0);

        // Byte enables, unimplemented bits, write-only and unused offsets
        bus_wr(A_IE, 16'hFFFF, 2'b10);
        bus_rd(A_IE, "ie.hi_byte", 16'h0022, 1'b0);
        bus_wr(A_IE, 16'hAB55, 2'b01);
        bus_rd(A_IE, "ie.lo_byte", 16'h0055, 1'b0);
        bus_wr(A_SET, 16'h0080, 2'b11);
        bus_rd(A_SET,   "set.rd0",   16'h0000, 1'b0);
        bus_rd(A_CLR,   "clr.rd0",   16'h0000, 1'b0);
        bus_rd(A_UNUSD, "unused.rd", 16'h0000, 1'b0);
        bus_rd(A_OTHER, "unsel.rd",  16'h0000, 1'b0);
        bus_rd(A_IV,    "iv.none",   16'h0000, 1'b0);
        bus_rd(A_IFG,   "ifg.80",    16'h0080, 1'b0);
        bus_wr(A_CLR, 16'h0080, 2'b11);

        // Asynchronous reset during a pending interrupt; sources held high
        bus_wr(A_SET, 16'h0001, 2'b11);
        chk_stat("pre_rst", 1'b1, 5'd1);
        irq_src[4] = 1'b1;
        @(negedge mclk);
        #2;
        puc_rst = 1'b1;
        chk_stat("rst.async", 1'b0, 5'd0);
        repeat (3) @(negedge mclk);
        puc_rst = 1'b0;
        repeat (5) @(negedge mclk);
        bus_rd(A_IFG, "post_rst.ifg", 16'h0011, 1'b0);
        bus_rd(A_IE,  "post_rst.ie",  16'h0000, 1'b0);
        chk_stat("post_rst", 1'b0, 5'd0);
        bus_wr(A_CLR, 16'h0011, 2'b11);
        repeat (5) @(negedge mclk);
        bus_rd(A_IFG, "single_set", 16'h0000, 1'b0);

        // IV read with irq_acc together clears once; IV read then irq_acc
        bus_wr(A_IE,  16'h00FF, 2'b11);
        bus_wr(A_SET, 16'h000B, 2'b11);
        bus_rd(A_IV,  "iv_acc.same", 16'h0002, 1'b1);
        bus_rd(A_IFG, "iv_acc.once", 16'h000A, 1'b0);
        bus_rd(A_IV,  "iv_then.iv",  16'h0004, 1'b0);
        pulse_acc();
        bus_rd(A_IFG, "iv_then.ifg", 16'h0000, 1'b0);
        chk_stat("final", 1'b0, 5'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pu_msp430_sfr_irq.md
# pu_msp430_sfr_irq

Parametrised interrupt special-function-register block: captures up to 16 asynchronous interrupt sources with per-channel edge selection, holds them in software-accessible enable/flag registers, and presents a prioritised interrupt vector to the CPU. Sits on the peripheral bus beside the core SFR block and generalises its single NMI/watchdog flag pair to NUM_CH maskable channels, adding set/clear aliases, a self-clearing vector register and a CPU accept handshake.

## Interface

- BASE_ADDR, 15'h0100, byte base address, aligned to 2^DEC_WD
- DEC_WD, 4, address decoder width in bits
- NUM_CH, 8, channel count, legal 1..16
- SYNC_STAGES, 2, source synchroniser depth, legal 0..3 (0 = sources already mclk-synchronous)

- mclk  in  1  main system clock
- puc_rst  in  1  reset: asynchronous, active-high
- irq_src  in  NUM_CH  interrupt sources, asynchronous, glitch-free
- irq_acc  in  1  CPU accepted the pending interrupt (single-cycle pulse)
- per_addr  in  14  peripheral word address
- per_din  in  16  peripheral write data
- per_en  in  1  peripheral enable
- per_we  in  2  byte write enables ([0] low, [1] high)
- per_dout  out  16  read data, 0 when not selected
- irq_pnd  out  1  any enabled flag set
- irq_vec  out  5  index+1 of highest-priority pending channel, 0 if none
- irq_wkup  out  1  wakeup request, equals irq_pnd

## Operation

- Selection: per_en & per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]; word offset = per_addr[DEC_WD-2:0]. Read = selected & per_we==0.
- Byte offsets: IE 0x0 (RW), IES 0x2 (RW, 1 = falling edge), IFG 0x4 (RW), IFGSET 0x6 (W1S, reads 0), IFGCLR 0x8 (W1C, reads 0), IV 0xA (RO). Unused offsets read 0, writes ignored.
- Byte writes honour per_we per byte; bits >= NUM_CH read 0 and ignore writes.
- Edge path per channel: irq_src -> SYNC_STAGES flops -> s; pol = s ^ IES; dly <= pol each cycle; edge = pol & ~dly.
- IES write: dly of each written channel loads s ^ IES_new in the same cycle, so changing polarity never creates an edge.
- IFG next state per bit, highest priority first: edge -> 1; IFGSET bit 1 -> 1; IFG write -> per_din bit; IFGCLR bit 1 -> 0; clear-by-vector -> 0; else hold.
- pending = IFG & IE; priority: lowest index wins. irq_vec = lowest set index + 1, 0 if none. IV reads {10'b0, irq_vec, 1'b0} (0x2, 0x4, ... 0x20).
- Clear-by-vector: IV read cycle, or irq_acc=1, clears the flag of the channel in irq_vec that cycle; both together clear that one channel once. No-op when irq_vec=0.
- irq_pnd = |pending; irq_wkup = irq_pnd (combinational).

## Timing

- Reset: IE, IES, IFG, sync flops, dly = 0; per_dout, irq_pnd, irq_vec, irq_wkup = 0.
- per_dout combinational in the read cycle; register updates at the closing mclk edge.
- Source latency: irq_src change sampled at edge k -> IFG set visible after edge k+SYNC_STAGES (SYNC_STAGES=0: after edge k).
- irq_pnd/irq_vec follow IFG/IE combinationally, zero extra latency.
- Source edge in same cycle as any clear of that bit: flag stays/becomes 1 (edge wins).
- Source held high through reset with IES=0: exactly one IFG set after release (dly resets 0).
- IV read then irq_acc next cycle: second clear targets the new highest-priority channel.
- Reset mid-operation: all state returns to reset values asynchronously; in-flight edges lost.

## Test plan

- Reset, IE=0x00FF, pulse irq_src[3] high 4 cycles (SYNC_STAGES=2) -> IFG=0x0008 after 2 edges, irq_pnd=1, irq_vec=4, IV read=0x0008 and clears IFG to 0.
- IFGSET 0x0022, IE=0x0022 -> irq_vec=2; irq_acc pulse -> IFG=0x0020, irq_vec=6; second irq_acc -> IFG=0, irq_pnd=0.
- IES bit2 0->1 with irq_src[2] held high -> no flag; drive low -> IFG bit2=1 after sync latency.
- Edge on ch0 in same cycle as IFGCLR 0x0001 -> IFG bit0=1.
- Byte write per_we=2'b10 of 0xFFFF to IE with NUM_CH=8 -> IE unchanged, reads 0x00xx; IFGSET/IFGCLR/unused offset reads 0.
- Assert puc_rst during pending interrupt -> all outputs 0 immediately; source held high through release -> single IFG set.
